// File: rtl/cla_wide_sequencer_pkg.sv
// Shared types and constants for the limb-serial multi-precision adder.
// Imported by the top module; the adder sub-module is self-contained.
package cla_seq_pkg;

    localparam int LIMB_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Limb index width; a single-limb build still needs one bit of index.
    function automatic int idx_w(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/cla_wide_sequencer_cla16.sv
// 16-bit carry-lookahead adder: four 4-bit lookahead groups chained by
// group generate/propagate. Signed overflow is reported only when sign=1.
module CLA_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    input  logic        control,
    input  logic        sign,
    output logic [15:0] sum,
    output logic        cout,
    output logic        OF
);

    logic [15:0] bx_s;
    logic [15:0] p_s;
    logic [15:0] g_s;
    logic [16:0] c_s;
    logic        gg_s;
    logic        pg_s;
    logic        cg_s;

    // Lookahead carry network, sum and overflow.
    always_comb begin
        bx_s = b ^ {16{control}};
        p_s  = a ^ bx_s;
        g_s  = a & bx_s;
        c_s  = 17'd0;
        gg_s = 1'b0;
        pg_s = 1'b0;
        cg_s = 1'b0;
        c_s[0] = cin;
        for (int k = 0; k < 4; k++) begin
            cg_s = c_s[4*k];
            c_s[4*k+1] = g_s[4*k] | (p_s[4*k] & cg_s);
            c_s[4*k+2] = g_s[4*k+1] | (p_s[4*k+1] & g_s[4*k])
                       | (p_s[4*k+1] & p_s[4*k] & cg_s);
            c_s[4*k+3] = g_s[4*k+2] | (p_s[4*k+2] & g_s[4*k+1])
                       | (p_s[4*k+2] & p_s[4*k+1] & g_s[4*k])
                       | (p_s[4*k+2] & p_s[4*k+1] & p_s[4*k] & cg_s);
            gg_s = g_s[4*k+3] | (p_s[4*k+3] & g_s[4*k+2])
                 | (p_s[4*k+3] & p_s[4*k+2] & g_s[4*k+1])
                 | (p_s[4*k+3] & p_s[4*k+2] & p_s[4*k+1] & g_s[4*k]);
            pg_s = &p_s[4*k +: 4];
            c_s[4*k+4] = gg_s | (pg_s & cg_s);
        end
        sum  = p_s ^ c_s[15:0];
        cout = c_s[16];
        if (sign) begin
            OF = (a[15] == bx_s[15]) & (sum[15] != a[15]);
        end else begin
            OF = 1'b0;
        end
    end

endmodule

// File: rtl/cla_wide_sequencer.sv
// Multi-precision add/subtract that walks one 16-bit CLA across WORDS limbs,
// LSB limb first, chaining the carry through a register between limbs.
module cla_wide_sequencer
    import cla_seq_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LIMB_W*WORDS-1:0] in_a,
    input  logic [LIMB_W*WORDS-1:0] in_b,
    input  logic                    in_sub,
    input  logic                    in_sign,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LIMB_W*WORDS-1:0] out_sum,
    output logic                    out_cout,
    output logic                    out_of,
    output logic                    busy
);

    localparam int IDX_W = idx_w(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    state_t                          state_r;
    logic [IDX_W-1:0]                idx_r;
    logic [WORDS-1:0][LIMB_W-1:0]    a_r;
    logic [WORDS-1:0][LIMB_W-1:0]    b_r;
    logic [WORDS-1:0][LIMB_W-1:0]    sum_r;
    logic                            sub_r;
    logic                            sign_r;
    logic                            carry_r;
    logic                            cout_r;
    logic                            of_r;
    logic                            in_ready_r;
    logic                            out_valid_r;
    logic                            busy_r;

    logic                            last_s;
    logic [LIMB_W-1:0]               add_a_s;
    logic [LIMB_W-1:0]               add_b_s;
    logic                            add_sign_s;
    logic [LIMB_W-1:0]               add_sum_s;
    logic                            add_cout_s;
    logic                            add_of_s;
    logic                            flag_s;

    // Limb select; subtraction inverts B here so the adder always adds.
    always_comb begin
        last_s     = (idx_r == LAST_IDX);
        add_a_s    = a_r[idx_r];
        add_b_s    = b_r[idx_r] ^ {LIMB_W{sub_r}};
        if (last_s) begin
            add_sign_s = sign_r;
        end else begin
            add_sign_s = 1'b0;
        end
        if (sign_r) begin
            flag_s = add_of_s;
        end else begin
            flag_s = add_cout_s ^ sub_r;
        end
    end

    CLA_16bit u_cla (
        .a       (add_a_s),
        .b       (add_b_s),
        .cin     (carry_r),
        .control (1'b0),
        .sign    (add_sign_s),
        .sum     (add_sum_s),
        .cout    (add_cout_s),
        .OF      (add_of_s)
    );

    // Sequencer FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            idx_r       <= '0;
            a_r         <= '0;
            b_r         <= '0;
            sum_r       <= '0;
            sub_r       <= 1'b0;
            sign_r      <= 1'b0;
            carry_r     <= 1'b0;
            cout_r      <= 1'b0;
            of_r        <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_r        <= in_a;
                        b_r        <= in_b;
                        sub_r      <= in_sub;
                        sign_r     <= in_sign;
                        idx_r      <= '0;
                        carry_r    <= in_sub;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                        state_r    <= RUN;
                    end else begin
                        state_r    <= IDLE;
                    end
                end
                RUN: begin
                    sum_r[idx_r] <= add_sum_s;
                    carry_r      <= add_cout_s;
                    if (last_s) begin
                        cout_r      <= add_cout_s;
                        of_r        <= flag_s;
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end else begin
                        idx_r       <= idx_r + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= IDLE;
                    end else begin
                        state_r     <= DONE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    busy_r      <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_sum   = sum_r;
    assign out_cout  = cout_r;
    assign out_of    = of_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_cla_wide_sequencer.sv
// Directed bench: a table of 64-bit operations on a 4-limb instance plus
// handshake, reset and single-limb sequences.
module tb_cla_wide_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid = 1'b0, in_sub = 1'b0, in_sign = 1'b0, out_ready = 1'b0;
    logic [63:0] in_a = 64'd0, in_b = 64'd0;
    logic        in_ready, out_valid, out_cout, out_of, busy;
    logic [63:0] out_sum;

    logic        in1_valid = 1'b0, in1_sub = 1'b0, in1_sign = 1'b0, out1_ready = 1'b0;
    logic [15:0] in1_a = 16'd0, in1_b = 16'd0;
    logic        in1_ready, out1_valid, out1_cout, out1_of, busy1;
    logic [15:0] out1_sum;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    cla_wide_sequencer #(.WORDS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .in_sub(in_sub), .in_sign(in_sign),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .out_cout(out_cout), .out_of(out_of), .busy(busy)
    );

    cla_wide_sequencer #(.WORDS(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in1_valid), .in_ready(in1_ready), .in_a(in1_a), .in_b(in1_b),
        .in_sub(in1_sub), .in_sign(in1_sign),
        .out_valid(out1_valid), .out_ready(out1_ready), .out_sum(out1_sum),
        .out_cout(out1_cout), .out_of(out1_of), .busy(busy1)
    );

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        sub;
        logic        sign;
        logic [63:0] sum;
        logic        cout;
        logic        of;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Present one operation, count cycles to out_valid, then drain it.
    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic sub,
                          input logic sign, output logic [63:0] sum, output logic cout,
                          output logic of, output int lat);
        @(negedge clk);
        in_a = a; in_b = b; in_sub = sub; in_sign = sign; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            #1 lat++;
        end
        sum = out_sum; cout = out_cout; of = out_of;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    logic [63:0] r_sum;
    logic        r_cout, r_of;
    int          r_lat;

    initial begin
        vecs[0] = '{64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b1};
        vecs[2] = '{64'h5, 64'h7, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1};
        vecs[3] = '{64'h7, 64'h5, 1'b1, 1'b0, 64'h2, 1'b1, 1'b0};
        vecs[4] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b1, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
        vecs[5] = '{64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
        vecs[6] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFB, 1'b1, 1'b0};
        vecs[7] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0, 64'h2222_2222_2222_2211, 1'b0, 1'b0};

        #12;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_out_sum", out_sum, 64'd0);
        chk("rst_cout_of", {62'd0, out_cout, out_of}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].sign, r_sum, r_cout, r_of, r_lat);
            chk($sformatf("vec%0d_sum", i), r_sum, vecs[i].sum);
            chk($sformatf("vec%0d_cout", i), {63'd0, r_cout}, {63'd0, vecs[i].cout});
            chk($sformatf("vec%0d_of", i), {63'd0, r_of}, {63'd0, vecs[i].of});
            chk($sformatf("vec%0d_latency", i), 64'(r_lat), 64'd4);
        end

        // Backpressure: result held 5 cycles while a second request waits.
        @(negedge clk);
        in_a = 64'd1; in_b = 64'd2; in_sub = 1'b0; in_sign = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_a = 64'd100; in_b = 64'd200;
        chk("bp_busy_run", {63'd0, busy}, 64'd1);
        r_lat = 0;
        while (!out_valid && r_lat < 50) begin
            @(posedge clk);
            #1 r_lat++;
        end
        chk("bp_latency", 64'(r_lat), 64'd4);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp_valid_c%0d", c), {63'd0, out_valid}, 64'd1);
            chk($sformatf("bp_sum_c%0d", c), out_sum, 64'd3);
            chk($sformatf("bp_in_ready_c%0d", c), {63'd0, in_ready}, 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk("bp_in_ready_back", {63'd0, in_ready}, 64'd1);
        chk("bp_valid_clear", {63'd0, out_valid}, 64'd0);
        chk("bp_sum_hold", out_sum, 64'd3);
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk("bp_queued_accepted", {62'd0, in_ready, busy}, 64'd1);
        r_lat = 0;
        while (!out_valid && r_lat < 50) begin
            @(posedge clk);
            #1 r_lat++;
        end
        chk("bp_queued_sum", out_sum, 64'd300);
        chk("bp_queued_latency", 64'(r_lat), 64'd4);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;

        // Reset while the third limb is being processed.
        @(negedge clk);
        in_a = 64'h1111_2222_3333_4444; in_b = 64'h1111_1111_1111_1111;
        in_sub = 1'b0; in_sign = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_sum", out_sum, 64'd0);
        chk("mid_rst_valid_busy", {62'd0, out_valid, busy}, 64'd0);
        chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
        run_op(64'h1234, 64'h0001, 1'b0, 1'b0, r_sum, r_cout, r_of, r_lat);
        chk("post_rst_sum", r_sum, 64'h1235);
        chk("post_rst_flags", {62'd0, r_cout, r_of}, 64'd0);
        chk("post_rst_latency", 64'(r_lat), 64'd4);

        // Single-limb instance: FFFF + 1.
        @(negedge clk);
        in1_a = 16'hFFFF; in1_b = 16'h0001; in1_sub = 1'b0; in1_sign = 1'b0; in1_valid = 1'b1;
        @(posedge clk);
        #1 in1_valid = 1'b0;
        r_lat = 0;
        while (!out1_valid && r_lat < 50) begin
            @(posedge clk);
            #1 r_lat++;
        end
        chk("w1_sum", {48'd0, out1_sum}, 64'd0);
        chk("w1_cout", {63'd0, out1_cout}, 64'd1);
        chk("w1_of", {63'd0, out1_of}, 64'd1);
        chk("w1_latency", 64'(r_lat), 64'd1);
        out1_ready = 1'b1;
        @(posedge clk);
        #1 out1_ready = 1'b0;

        // Single-limb signed: 7FFF + 1 overflows using the captured sign.
        @(negedge clk);
        in1_a = 16'h7FFF; in1_b = 16'h0001; in1_sub = 1'b0; in1_sign = 1'b1; in1_valid = 1'b1;
        @(posedge clk);
        #1 in1_valid = 1'b0;
        r_lat = 0;
        while (!out1_valid && r_lat < 50) begin
            @(posedge clk);
            #1 r_lat++;
        end
        chk("w1s_sum", {48'd0, out1_sum}, 64'h8000);
        chk("w1s_of", {63'd0, out1_of}, 64'd1);
        chk("w1s_cout", {63'd0, out1_cout}, 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
